i2c_bus_fabric: RTL and testbench
=================================

Name: i2c_bus_fabric

Overview:
- Parametrised successor to the two-agent wired-AND I2C bus model.
- Resolves SDA/SCL open-drain intents from N_AGENTS agents and exposes the raw resolved lines.
- Adds a clocked bus monitor:
  - 2-FF synchronisers and a glitch filter;
  - START/STOP/repeated-START detection and bus busy tracking;
  - per-agent arbitration-loss flags;
  - SCL-low timeout.
- Sits between the I2C master/slave FSMs and the testbench/top level.

Parameters:
- N_AGENTS, 2, number of attached agents (masters plus slaves), ≥1.
- FILT_LEN, 3, consecutive sys-clk cycles a synced level must persist before the filtered line changes, ≥1.
- TIMEOUT_CYC, 1000, sys-clk cycles of filtered SCL low while busy before timeout. 0 disables timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sda_low_intent  in  N_AGENTS  bit i=1: agent i pulls SDA low.
- scl_low_intent  in  N_AGENTS  bit i=1: agent i pulls SCL low.
- agent_tx_en  in  N_AGENTS  bit i=1: agent i is currently transmitting on SDA (arbitration qualifier).
- SDA  inout  1  resolved bus line.
- SCL  inout  1  resolved bus line.
- sda_in  out  1  raw resolved SDA (combinational).
- scl_in  out  1  raw resolved SCL (combinational).
- sda_f  out  1  synchronised + filtered SDA.
- scl_f  out  1  synchronised + filtered SCL.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- bus_busy  out  1  high between START and STOP.
- arb_lost  out  N_AGENTS  sticky per-agent arbitration-lost flags.
- scl_timeout  out  1  one-cycle pulse on SCL-low timeout.

Behaviour:
- Resolution (combinational, independent of clk/rst):
  - SDA = 0 if any sda_low_intent bit is set, else 1 (modelled pull-up). SCL likewise from scl_low_intent.
  - sda_in = SDA; scl_in = SCL.
- Reset (one clk edge with rst=1):
  - Sync FFs and sda_f/scl_f = 1; filter counters = 0; FSM = IDLE.
  - start_det, stop_det, bus_busy, scl_timeout = 0; arb_lost = 0; timeout counter = 0.
  - Reset mid-transfer aborts the transfer; no STOP pulse is generated.
- Synchroniser: 2-FF per line, reset value 1.
- Filter, per line:
  - Counter increments while sync output ≠ filtered output; cleared when they are equal.
  - When the counter reaches FILT_LEN, the filtered output toggles and the counter clears.
  - A pulse shorter than FILT_LEN cycles is fully rejected.
  - Latency from raw edge to filtered edge = 2 + FILT_LEN cycles.
  - Counter width $clog2(FILT_LEN+1).
- Condition detect, on registered previous filtered values:
  - START: scl_f=1 both cycles and sda_f falls 1→0.
  - STOP: scl_f=1 both cycles and sda_f rises 0→1.
  - Pulses are registered: asserted the cycle after the filtered edge.
  - If sda_f and scl_f change in the same cycle, no condition is detected.
- FSM IDLE/BUSY:
  - IDLE --START--> BUSY.
  - BUSY --STOP--> IDLE.
  - BUSY --START--> BUSY (repeated START; start_det pulses, bus_busy stays 1).
  - STOP seen in IDLE: stop_det still pulses; state stays IDLE.
  - bus_busy = (state==BUSY), registered.
- Arbitration, per agent i:
  - Sampled on scl_f rising edge (prev 0, now 1) while BUSY.
  - Set arb_lost[i] if agent_tx_en[i]=1 and sda_low_intent[i]=0 and sda_f=0.
  - Sticky; cleared only by the stop_det cycle or rst.
  - If set and clear coincide, clear wins.
  - Multiple bits may be set simultaneously.
- Timeout:
  - Counter increments each cycle while BUSY and scl_f=0; saturates at TIMEOUT_CYC.
  - scl_timeout pulses exactly once, on the cycle the count reaches TIMEOUT_CYC.
  - Counter clears when scl_f=1 or in IDLE.
  - TIMEOUT_CYC=0: output tied 0 and counter removed.
  - Counter width $clog2(TIMEOUT_CYC+1).

Optional Feature:
- Macro: I2C_BUS_STATS_EN.
- Defined: adds outputs start_cnt[15:0], stop_cnt[15:0], arb_cnt[15:0].
  - start_cnt increments on start_det; stop_cnt increments on stop_det.
  - arb_cnt increments on any 0→1 transition of any arb_lost bit (+1 per cycle, regardless of how many bits rise).
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package i2c_pkg:
  - FSM state typedef (BUS_IDLE, BUS_BUSY);
  - default FILT_LEN/TIMEOUT_CYC constants;
  - stats counter width constant (16).
- One natural sub-module: i2c_line_filter (2-FF sync + glitch filter, one line, parameter FILT_LEN), instantiated twice.

Test Plan:
- Reset then idle, all intents 0 → SDA=SCL=1, sda_f=scl_f=1, bus_busy=0, no pulses.
- FILT_LEN=3: 2-cycle SDA low glitch while SCL high → sda_f stays 1, no start_det. 5-cycle SDA low → sda_f falls 5 cycles after raw edge, start_det pulse next cycle, bus_busy=1.
- START, 9 SCL pulses, repeated START, STOP → start_det ×2, stop_det ×1, bus_busy 1→0 after STOP.
- N_AGENTS=3: agents 0 and 2 tx_en=1. Agent 0 sends 0xA0, agent 2 sends 0xB0 → arb_lost=3'b100 from bit 4 onward, cleared by STOP; SDA always equals the AND of the two agents' bit values.
- TIMEOUT_CYC=50: agent holds SCL low for 60 cycles while BUSY → single scl_timeout pulse on the 50th low cycle; no further pulse until SCL released and held low again.
- I2C_BUS_STATS_EN defined: 3 transactions, one of them arbitrated → start_cnt=3, stop_cnt=3, arb_cnt=1. rst → all 0.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C bus fabric.
//            - bus_state_t : bus monitor state (idle / busy)
//            - default filter length and SCL-low timeout
//            - statistics counter width
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    localparam int c_def_filt_len    = 3;
    localparam int c_def_timeout_cyc = 1000;
    localparam int c_stats_w         = 16;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_filter
// Purpose  : Two-flop synchroniser followed by a persistence glitch filter
//            for one open-drain bus line. The filtered output only follows
//            the synchronised level after that level has differed from it
//            for FILT_LEN consecutive cycles. Raw-to-filtered latency is
//            2 + FILT_LEN cycles.
// Ports    : clk      - system clock
//            rst      - synchronous active-high reset (line idles high)
//            i_line   - raw resolved line (asynchronous to clk)
//            o_line_f - synchronised, filtered line
// Revision : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_line_f
);

    localparam int                  c_cnt_w    = $clog2(FILT_LEN + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(FILT_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_filt;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_filt  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // This edge is the FILT_LEN-th consecutive disagreeing cycle.
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign o_line_f = r_filt;

endmodule : i2c_line_filter
`default_nettype wire

// File: rtl/i2c_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_fabric
// Purpose  : Wired-AND resolution of SDA/SCL for N_AGENTS agents plus a
//            clocked bus monitor: synchronised/filtered lines, START/STOP
//            detection, bus-busy tracking, sticky per-agent arbitration-loss
//            flags and an SCL-low timeout.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            sda_low_intent[N]      - agent i pulls SDA low
//            scl_low_intent[N]      - agent i pulls SCL low
//            agent_tx_en[N]         - agent i is transmitting on SDA
//            SDA, SCL               - resolved bus lines
//            sda_in, scl_in         - raw resolved lines (combinational)
//            sda_f, scl_f           - synchronised + filtered lines
//            start_det, stop_det    - one-cycle condition pulses
//            bus_busy               - high between START and STOP
//            arb_lost[N]            - sticky arbitration-lost flags
//            scl_timeout            - one-cycle SCL-low timeout pulse
//            start_cnt, stop_cnt,
//            arb_cnt                - saturating event counters, present
//                                     only when I2C_BUS_STATS_EN is defined
// Options  : I2C_BUS_STATS_EN - adds the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_fabric
    import i2c_pkg::*;
#(
    parameter int N_AGENTS    = 2,
    parameter int FILT_LEN    = c_def_filt_len,
    parameter int TIMEOUT_CYC = c_def_timeout_cyc
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_AGENTS-1:0]   sda_low_intent,
    input  logic [N_AGENTS-1:0]   scl_low_intent,
    input  logic [N_AGENTS-1:0]   agent_tx_en,
    inout  wire                   SDA,
    inout  wire                   SCL,
    output logic                  sda_in,
    output logic                  scl_in,
    output logic                  sda_f,
    output logic                  scl_f,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  bus_busy,
    output logic [N_AGENTS-1:0]   arb_lost,
`ifdef I2C_BUS_STATS_EN
    output logic [c_stats_w-1:0]  start_cnt,
    output logic [c_stats_w-1:0]  stop_cnt,
    output logic [c_stats_w-1:0]  arb_cnt,
`endif
    output logic                  scl_timeout
);

    // ------------------------------------------------------------------
    // Wired-AND resolution with a modelled pull-up
    // ------------------------------------------------------------------
    logic w_sda_res;
    logic w_scl_res;

    assign w_sda_res = ~(|sda_low_intent);
    assign w_scl_res = ~(|scl_low_intent);
    assign SDA       = w_sda_res;
    assign SCL       = w_scl_res;
    assign sda_in    = w_sda_res;
    assign scl_in    = w_scl_res;

    // ------------------------------------------------------------------
    // Synchronise and filter both lines
    // ------------------------------------------------------------------
    logic w_sda_f;
    logic w_scl_f;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
        .clk      (clk),
        .rst      (rst),
        .i_line   (w_sda_res),
        .o_line_f (w_sda_f)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
        .clk      (clk),
        .rst      (rst),
        .i_line   (w_scl_res),
        .o_line_f (w_scl_f)
    );

    assign sda_f = w_sda_f;
    assign scl_f = w_scl_f;

    // ------------------------------------------------------------------
    // Condition detect and bus state
    // ------------------------------------------------------------------
    bus_state_t           r_state;
    logic                 r_sda_prev;
    logic                 r_scl_prev;
    logic                 r_start_det;
    logic                 r_stop_det;
    logic [N_AGENTS-1:0]  r_arb_lost;

    logic                 w_start;
    logic                 w_stop;
    logic                 w_scl_rise;
    logic [N_AGENTS-1:0]  w_arb_set;
    logic [N_AGENTS-1:0]  w_arb_next;

    // Requiring SCL high on both samples also rejects simultaneous edges.
    assign w_start    = r_scl_prev & w_scl_f &  r_sda_prev & ~w_sda_f;
    assign w_stop     = r_scl_prev & w_scl_f & ~r_sda_prev &  w_sda_f;
    assign w_scl_rise = ~r_scl_prev & w_scl_f;

    // An agent loses when it released SDA but the bus reads low.
    assign w_arb_set  = (w_scl_rise && (r_state == BUS_BUSY))
                      ? (agent_tx_en & ~sda_low_intent & {N_AGENTS{~w_sda_f}})
                      : '0;
    // Clearing on the stop_det cycle dominates any concurrent set.
    assign w_arb_next = r_stop_det ? '0 : (r_arb_lost | w_arb_set);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BUS_IDLE;
            r_sda_prev  <= 1'b1;
            r_scl_prev  <= 1'b1;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_arb_lost  <= '0;
        end else begin
            r_sda_prev  <= w_sda_f;
            r_scl_prev  <= w_scl_f;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
            r_arb_lost  <= w_arb_next;
            case (r_state)
                BUS_IDLE: if (w_start) r_state <= BUS_BUSY;
                BUS_BUSY: if (w_stop)  r_state <= BUS_IDLE;
                default:               r_state <= BUS_IDLE;
            endcase
        end
    end

    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;
    assign bus_busy  = (r_state == BUS_BUSY);
    assign arb_lost  = r_arb_lost;

    // ------------------------------------------------------------------
    // SCL-low timeout
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam int                c_to_w   = $clog2(TIMEOUT_CYC + 1);
            localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYC);
            localparam logic [c_to_w-1:0] c_to_one = c_to_w'(1);

            logic [c_to_w-1:0] r_to_cnt;
            logic              r_to_pulse;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_to_cnt   <= '0;
                    r_to_pulse <= 1'b0;
                end else if ((r_state == BUS_BUSY) && !w_scl_f) begin
                    // Saturation keeps the pulse to a single cycle per low period.
                    if (r_to_cnt != c_to_max) r_to_cnt <= r_to_cnt + c_to_one;
                    r_to_pulse <= (r_to_cnt == (c_to_max - c_to_one));
                end else begin
                    r_to_cnt   <= '0;
                    r_to_pulse <= 1'b0;
                end
            end

            assign scl_timeout = r_to_pulse;
        end else begin : g_no_timeout
            assign scl_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional event statistics
    // ------------------------------------------------------------------
`ifdef I2C_BUS_STATS_EN
    localparam logic [c_stats_w-1:0] c_stats_max = '1;
    localparam logic [c_stats_w-1:0] c_stats_one = c_stats_w'(1);

    logic [c_stats_w-1:0] r_start_cnt;
    logic [c_stats_w-1:0] r_stop_cnt;
    logic [c_stats_w-1:0] r_arb_cnt;
    logic                 w_arb_rise;

    // One count per cycle however many flags rise together.
    assign w_arb_rise = |(w_arb_next & ~r_arb_lost);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_cnt <= '0;
            r_stop_cnt  <= '0;
            r_arb_cnt   <= '0;
        end else begin
            if (r_start_det && (r_start_cnt != c_stats_max)) r_start_cnt <= r_start_cnt + c_stats_one;
            if (r_stop_det  && (r_stop_cnt  != c_stats_max)) r_stop_cnt  <= r_stop_cnt  + c_stats_one;
            if (w_arb_rise  && (r_arb_cnt   != c_stats_max)) r_arb_cnt   <= r_arb_cnt   + c_stats_one;
        end
    end

    assign start_cnt = r_start_cnt;
    assign stop_cnt  = r_stop_cnt;
    assign arb_cnt   = r_arb_cnt;
`endif

endmodule : i2c_bus_fabric
`default_nettype wire

// File: tb/tb_i2c_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_fabric
// Purpose  : Self-checking bench for i2c_bus_fabric (N_AGENTS=3, FILT_LEN=3,
//            TIMEOUT_CYC=50). Bus events (START/STOP/timeout) are predicted
//            into a queue as stimulus is driven and compared in order with
//            the events observed on the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_fabric;

    localparam int N  = 3;
    localparam int FL = 3;
    localparam int TO = 50;
    localparam int HP = 8;    // cycles per bus phase, longer than filter latency

    localparam int EV_START = 1;
    localparam int EV_STOP  = 2;
    localparam int EV_TO    = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sda_li = '0;
    logic [N-1:0] scl_li = '0;
    logic [N-1:0] tx_en  = '0;
    wire          SDA;
    wire          SCL;
    logic         sda_in, scl_in, sda_f, scl_f;
    logic         start_det, stop_det, bus_busy, scl_timeout;
    logic [N-1:0] arb_lost;
`ifdef I2C_BUS_STATS_EN
    logic [15:0]  start_cnt, stop_cnt, arb_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_q[$];

    always #5 clk = ~clk;

    i2c_bus_fabric #(
        .N_AGENTS    (N),
        .FILT_LEN    (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sda_low_intent (sda_li),
        .scl_low_intent (scl_li),
        .agent_tx_en    (tx_en),
        .SDA            (SDA),
        .SCL            (SCL),
        .sda_in         (sda_in),
        .scl_in         (scl_in),
        .sda_f          (sda_f),
        .scl_f          (scl_f),
        .start_det      (start_det),
        .stop_det       (stop_det),
        .bus_busy       (bus_busy),
        .arb_lost       (arb_lost),
`ifdef I2C_BUS_STATS_EN
        .start_cnt      (start_cnt),
        .stop_cnt       (stop_cnt),
        .arb_cnt        (arb_cnt),
`endif
        .scl_timeout    (scl_timeout)
    );

    // Event monitor feeding the observed side of the scoreboard.
    always @(negedge clk) begin
        if (start_det)   obs_q.push_back(EV_START);
        if (stop_det)    obs_q.push_back(EV_STOP);
        if (scl_timeout) obs_q.push_back(EV_TO);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Agent 0 drives both lines; 1 means released.
    task automatic drive0(input bit sda, input bit scl);
        sda_li[0] = ~sda;
        scl_li[0] = ~scl;
        tick(HP);
    endtask

    task automatic send_start();
        drive0(1'b1, 1'b0);
        drive0(1'b1, 1'b1);
        exp_q.push_back(EV_START);
        drive0(1'b0, 1'b1);
        drive0(1'b0, 1'b0);
    endtask

    task automatic send_bit(input bit b);
        drive0(b, 1'b0);
        drive0(b, 1'b1);
        drive0(b, 1'b0);
    endtask

    task automatic send_stop();
        drive0(1'b0, 1'b0);
        drive0(1'b0, 1'b1);
        exp_q.push_back(EV_STOP);
        drive0(1'b1, 1'b1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int e, o;
        exp_q.delete();
        rst = 1'b1;
        sda_li = 3'b010;
        #1;
        checks++;
        if (SDA !== 1'b0 || sda_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_resolve: SDA=%b sda_in=%b expected 0/0", SDA, sda_in);
        end
        sda_li = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if ({SDA, SCL, sda_in, scl_in, sda_f, scl_f, bus_busy, start_det, stop_det, scl_timeout}
            !== 10'b1111110000) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {SDA, SCL, sda_in, scl_in, sda_f, scl_f, bus_busy, start_det, stop_det, scl_timeout},
                     10'b1111110000);
        end
        checks++;
        if (arb_lost !== 3'b000) begin
            errors++;
            $display("FAIL reset_arb: got %b expected 000", arb_lost);
        end
        obs_q.delete();
        tick(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_event_order: got %0d expected %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_glitch_filter();
        int e, o;
        bit ex_sda, ex_start, ex_stop, ex_busy;
        exp_q.delete();
        obs_q.delete();
        // 2-cycle glitch: must be rejected.
        sda_li[0] = 1'b1;
        tick(2);
        sda_li[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            checks++;
            if (sda_f !== 1'b1 || start_det !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject k=%0d: sda_f=%b start_det=%b expected 1/0", k, sda_f, start_det);
            end
        end
        // 5-cycle low: accepted as START, release gives STOP.
        sda_li[0] = 1'b1;
        exp_q.push_back(EV_START);
        exp_q.push_back(EV_STOP);
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (k == 5) sda_li[0] = 1'b0;
            ex_sda   = !(k >= 5 && k < 10);
            ex_start = (k == 6);
            ex_stop  = (k == 11);
            ex_busy  = (k >= 6 && k < 11);
            checks++;
            if ({sda_f, start_det, stop_det, bus_busy} !== {ex_sda, ex_start, ex_stop, ex_busy}) begin
                errors++;
                $display("FAIL glitch_accept k=%0d: sda_f/start/stop/busy=%b expected %b", k,
                         {sda_f, start_det, stop_det, bus_busy}, {ex_sda, ex_start, ex_stop, ex_busy});
            end
        end
        tick(HP);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL glitch_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL glitch_event_order: got %0d expected %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_transfer();
        int e, o;
        logic [8:0] pat;
        exp_q.delete();
        obs_q.delete();
        pat = 9'h0AA;
        send_start();
        checks++;
        if (bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL xfer_busy_start: got %b expected 1", bus_busy);
        end
        for (int i = 8; i >= 0; i--) send_bit(pat[i]);
        send_start();
        checks++;
        if (bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL xfer_busy_rstart: got %b expected 1", bus_busy);
        end
        for (int i = 8; i >= 0; i--) send_bit(pat[i]);
        send_stop();
        tick(4);
        checks++;
        if (bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL xfer_busy_stop: got %b expected 0", bus_busy);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL xfer_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL xfer_event_order: got %0d expected %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_arbitration();
        int e, o;
        logic [7:0]   byte_a, byte_b;
        logic [N-1:0] exp_lost;
        bit a, b;
        exp_q.delete();
        obs_q.delete();
        byte_a   = 8'hA0;
        byte_b   = 8'hB0;
        exp_lost = '0;
        tx_en    = 3'b101;
        send_start();
        for (int i = 7; i >= 0; i--) begin
            a = byte_a[i];
            b = byte_b[i];
            sda_li[0] = ~a;
            sda_li[2] = ~b;
            tick(HP);
            checks++;
            if (SDA !== (a & b) || sda_in !== (a & b)) begin
                errors++;
                $display("FAIL arb_wired_and bit%0d: SDA=%b sda_in=%b expected %b", i, SDA, sda_in, a & b);
            end
            scl_li[0] = 1'b0;
            tick(HP);
            if ((a & b) == 1'b0) begin
                if (a) exp_lost[0] = 1'b1;
                if (b) exp_lost[2] = 1'b1;
            end
            checks++;
            if (arb_lost !== exp_lost) begin
                errors++;
                $display("FAIL arb_lost bit%0d: got %b expected %b", i, arb_lost, exp_lost);
            end
            scl_li[0] = 1'b1;
            tick(HP);
        end
        sda_li[2] = 1'b0;
        send_stop();
        tick(4);
        checks++;
        if (arb_lost !== 3'b000 || bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_clear: arb_lost=%b bus_busy=%b expected 000/0", arb_lost, bus_busy);
        end
        tx_en = '0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL arb_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL arb_event_order: got %0d expected %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        int e, o;
        int t0, tp, npulse;
        exp_q.delete();
        obs_q.delete();
        send_start();
        drive0(1'b0, 1'b1);
        for (int rep = 0; rep < 2; rep++) begin
            t0 = -1;
            tp = -1;
            npulse = 0;
            scl_li[1] = 1'b1;
            exp_q.push_back(EV_TO);
            for (int k = 1; k <= 60; k++) begin
                tick(1);
                if (scl_f === 1'b0 && t0 < 0) t0 = k;
                if (scl_timeout === 1'b1) begin
                    npulse++;
                    tp = k;
                end
            end
            checks++;
            if (npulse != 1) begin
                errors++;
                $display("FAIL timeout_pulses rep%0d: got %0d expected 1", rep, npulse);
            end
            checks++;
            if ((tp - t0) != TO) begin
                errors++;
                $display("FAIL timeout_delay rep%0d: got %0d expected %0d", rep, tp - t0, TO);
            end
            scl_li[1] = 1'b0;
            tick(HP + 4);
        end
        checks++;
        if (bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy: got %b expected 1", bus_busy);
        end
        send_stop();
        tick(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout_event_order: got %0d expected %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_abort();
        int e, o;
        exp_q.delete();
        obs_q.delete();
        send_start();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (bus_busy !== 1'b0 || sda_f !== 1'b1 || scl_f !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: busy/sda_f/scl_f=%b expected 011", {bus_busy, sda_f, scl_f});
        end
        tick(HP);
        checks++;
        if (bus_busy !== 1'b0 || sda_f !== 1'b0 || scl_f !== 1'b0) begin
            errors++;
            $display("FAIL abort_lines_low: busy/sda_f/scl_f=%b expected 000", {bus_busy, sda_f, scl_f});
        end
        // Both lines released together: no condition may be seen.
        sda_li[0] = 1'b0;
        scl_li[0] = 1'b0;
        tick(HP + 4);
        checks++;
        if (bus_busy !== 1'b0 || sda_f !== 1'b1 || scl_f !== 1'b1) begin
            errors++;
            $display("FAIL abort_release: busy/sda_f/scl_f=%b expected 011", {bus_busy, sda_f, scl_f});
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_event_order: got %0d expected %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

`ifdef I2C_BUS_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++;
        if ({start_cnt, stop_cnt, arb_cnt} !== 48'h0) begin
            errors++;
            $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0", start_cnt, stop_cnt, arb_cnt);
        end
        send_start();
        send_bit(1'b1);
        send_stop();
        test_arbitration();
        send_start();
        send_bit(1'b0);
        send_stop();
        tick(4);
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (start_cnt !== 16'd3 || stop_cnt !== 16'd3 || arb_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stats_counts: got %0d/%0d/%0d expected 3/3/1", start_cnt, stop_cnt, arb_cnt);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({start_cnt, stop_cnt, arb_cnt} !== 48'h0) begin
            errors++;
            $display("FAIL stats_clear: got %0d/%0d/%0d expected 0/0/0", start_cnt, stop_cnt, arb_cnt);
        end
        tick(HP);
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_glitch_filter();
        test_transfer();
        test_arbitration();
        test_timeout();
        test_reset_abort();
`ifdef I2C_BUS_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_i2c_bus_fabric
`default_nettype wire
